// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder.
// The state enum, array geometry and a saturating stats helper live here.
package main_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int MEM_WORDS       = 256;
   localparam int IDX_W           = 8;
   localparam int CNT_W           = 4;
   localparam int DEFAULT_LATENCY = 4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/main_mem_array.sv
// 256-word storage: synchronous write port, combinational read port, no reset.
// The responder registers the read word itself when the access commits.
module main_mem_array
   import main_mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [MEM_WORDS];

   // Word write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/main_memory_responder.sv
// Word-serial memory responder: accept, wait LATENCY edges, commit, pulse done.
// Define MAIN_MEM_STATS_EN to add saturating read/write completion counters.
module main_memory_responder
   import main_mem_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              request,
   input  logic              write_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] write_data_in,
   output logic              done,
   output logic [DATA_W-1:0] read_data_out
`ifdef MAIN_MEM_STATS_EN
   ,
   output logic [15:0]       read_count,
   output logic [15:0]       write_count
`endif
);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               we_q;
   logic [IDX_W-1:0]   idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               done_q;
   logic [DATA_W-1:0]  rdata_q;
   logic [DATA_W-1:0]  arr_rdata;
   logic               commit;
   logic               mem_we;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^addr_in[1:0];

   // A reset on the commit edge must suppress the write as well as the FSM step.
   assign commit = (state_q == WAIT) && (cnt_q == {CNT_W{1'b0}});
   assign mem_we = commit && we_q && !reset;

   main_mem_array #(.DATA_W(DATA_W)) u_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .raddr_i (idx_q),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         we_q    <= 1'b0;
         idx_q   <= {IDX_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         done_q  <= 1'b0;
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (request) begin
                  we_q    <= write_in;
                  idx_q   <= addr_in[IDX_W+1:2];
                  wdata_q <= write_data_in;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == {CNT_W{1'b0}}) begin
                  if (!we_q) begin
                     rdata_q <= arr_rdata;
                  end
                  done_q  <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            RESP: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done          = done_q;
   assign read_data_out = rdata_q;

`ifdef MAIN_MEM_STATS_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   // Completion counters step on the same edge as the commit and stick at full scale
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q <= 16'd0;
         wr_cnt_q <= 16'd0;
      end else if (commit) begin
         if (we_q) begin
            wr_cnt_q <= sat_inc16(wr_cnt_q);
         end else begin
            rd_cnt_q <= sat_inc16(rd_cnt_q);
         end
      end
   end

   assign read_count  = rd_cnt_q;
   assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed pins.
// Honours MAIN_MEM_STATS_EN when the design is built with it.
module tb_main_memory_responder;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, request, write_in;
   logic [9:0]  addr_in;
   logic [31:0] wdata, rdo;
   logic        done;
   logic        r1_reset, r1_req, r1_we;
   logic [9:0]  r1_addr;
   logic [31:0] r1_wdata, r1_rdo;
   logic        r1_done;
`ifdef MAIN_MEM_STATS_EN
   logic [15:0] rc, wc, r1_rc, r1_wc;
`endif

   main_memory_responder #(.LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .request(request), .write_in(write_in),
      .addr_in(addr_in), .write_data_in(wdata), .done(done), .read_data_out(rdo)
`ifdef MAIN_MEM_STATS_EN
      , .read_count(rc), .write_count(wc)
`endif
   );

   main_memory_responder #(.LATENCY(1)) dut1 (
      .clk(clk), .reset(r1_reset), .request(r1_req), .write_in(r1_we),
      .addr_in(r1_addr), .write_data_in(r1_wdata), .done(r1_done), .read_data_out(r1_rdo)
`ifdef MAIN_MEM_STATS_EN
      , .read_count(r1_rc), .write_count(r1_wc)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one access in flight, completes LAT edges after acceptance
   bit [31:0] m_mem [256];
   bit        started = 0;
   bit        pend = 0;
   int        cyc = 0, commit_cyc = 0, free_cyc = 0;
   bit        p_we;
   int        p_idx;
   bit [31:0] p_data;
   bit        m_done = 0;
   bit [31:0] m_rd = 0;
   bit [15:0] m_rc = 0, m_wc = 0;

   always @(posedge clk) begin
      cyc++;
      m_done = 0;
      if (reset) begin
         pend = 0; m_rd = 0; m_rc = 0; m_wc = 0;
         free_cyc = cyc + 1;
         started = 1;
      end else if (started) begin
         if (pend && cyc == commit_cyc) begin
            pend = 0;
            m_done = 1;
            free_cyc = cyc + 2;
            if (p_we) begin
               m_mem[p_idx] = p_data;
               if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            end else begin
               m_rd = m_mem[p_idx];
               if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
            end
         end else if (!pend && cyc >= free_cyc && request) begin
            pend = 1;
            commit_cyc = cyc + LAT;
            p_we = write_in;
            p_idx = int'(addr_in) / 4;
            p_data = wdata;
         end
      end
   end

   // Every-cycle comparison of the LATENCY=4 instance against the model
   always @(negedge clk) begin
      if (started) begin
         check("done", {31'd0, done}, {31'd0, m_done});
         check("read_data_out", rdo, m_rd);
`ifdef MAIN_MEM_STATS_EN
         check("read_count", {16'd0, rc}, {16'd0, m_rc});
         check("write_count", {16'd0, wc}, {16'd0, m_wc});
`endif
      end
   end

   // Called #1 after a rising edge with the target instance idle
   task automatic do_txn(input int which, input logic we, input logic [9:0] a,
                         input logic [31:0] d, input bit scr,
                         output int lat, output logic [31:0] rd);
      bit got;
      if (which == 0) begin
         request = 1'b1; write_in = we; addr_in = a; wdata = d;
      end else begin
         r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
      end
      @(posedge clk); #1;
      if (which == 0) request = 1'b0; else r1_req = 1'b0;
      lat = 0;
      got = 0;
      for (int t = 0; t < 40 && !got; t++) begin
         if (scr) begin
            addr_in = 10'($urandom); wdata = $urandom; write_in = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
         if ((which == 0) ? done : r1_done) got = 1;
      end
      rd = (which == 0) ? rdo : r1_rdo;
      if (!got) check("txn_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   int          lat, last;
   logic [31:0] rd;
   bit          got;

   initial begin
      reset = 1'b1; request = 1'b0; write_in = 1'b0; addr_in = 10'd0; wdata = 32'd0;
      r1_reset = 1'b1; r1_req = 1'b0; r1_we = 1'b0; r1_addr = 10'd0; r1_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_rdata", rdo, 32'd0);
      reset = 1'b0; r1_reset = 1'b0;

      // Clear the whole array through the port so every word has a known value
      for (int i = 0; i < 256; i++) do_txn(0, 1'b1, 10'(i * 4), 32'd0, 1'b0, lat, rd);

      do_txn(0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, lat, rd);
      check("wr_latency", 32'(lat), 32'd4);
      do_txn(0, 1'b0, 10'h010, 32'd0, 1'b0, lat, rd);
      check("rd_latency", 32'(lat), 32'd4);
      check("rd_deadbeef", rd, 32'hDEADBEEF);

      // Refill: preload 1..4, then hold request high across four reads
      for (int k = 0; k < 4; k++) do_txn(0, 1'b1, 10'(10'h040 + 4 * k), 32'(k + 1), 1'b0, lat, rd);
      request = 1'b1; write_in = 1'b0; addr_in = 10'h040;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(posedge clk); #1;
            if (done) got = 1;
         end
         check("refill_got", {31'd0, got}, 32'd1);
         check("refill_data", rdo, 32'(k + 1));
         if (k > 0) check("refill_period", 32'(cyc - last), 32'd6);
         last = cyc;
         addr_in = 10'(10'h040 + 4 * (k + 1));
      end
      request = 1'b0;
      @(posedge clk); #1;

      // Inputs scrambled during WAIT must not leak into the access
      do_txn(0, 1'b1, 10'h080, 32'hCAFEF00D, 1'b1, lat, rd);
      do_txn(0, 1'b0, 10'h080, 32'd0, 1'b1, lat, rd);
      check("scramble_data", rd, 32'hCAFEF00D);

      // Reset on the commit edge of a write discards it
      request = 1'b1; write_in = 1'b1; addr_in = 10'h3FC; wdata = 32'h12345678;
      @(posedge clk); #1;
      request = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_commit_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      check("rst_commit_done2", {31'd0, done}, 32'd0);
      do_txn(0, 1'b0, 10'h3FC, 32'd0, 1'b0, lat, rd);
      check("rst_commit_data", rd, 32'd0);

      // LATENCY=1 instance: byte-offset bits ignored, one-edge completion
      do_txn(1, 1'b1, 10'h013, 32'hA5A5A5A5, 1'b0, lat, rd);
      check("lat1_wr_latency", 32'(lat), 32'd1);
      do_txn(1, 1'b0, 10'h010, 32'd0, 1'b0, lat, rd);
      check("lat1_rd_latency", 32'(lat), 32'd1);
      check("lat1_rd_data", rd, 32'hA5A5A5A5);

`ifdef MAIN_MEM_STATS_EN
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) do_txn(0, 1'b1, 10'(10'h100 + 4 * k), 32'(k), 1'b0, lat, rd);
      for (int k = 0; k < 2; k++) do_txn(0, 1'b0, 10'(10'h100 + 4 * k), 32'd0, 1'b0, lat, rd);
      check("stats_wc", {16'd0, wc}, 32'd3);
      check("stats_rc", {16'd0, rc}, 32'd2);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("stats_wc_rst", {16'd0, wc}, 32'd0);
      check("stats_rc_rst", {16'd0, rc}, 32'd0);
`endif

      // Random traffic with occasional resets; the model checks every cycle
      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 299) == 0);
         request = ($urandom_range(0, 3) != 0);
         write_in = 1'($urandom);
         addr_in = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
         wdata   = $urandom;
         @(posedge clk); #1;
      end
      reset = 1'b0; request = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
